// File: rtl/param_counter_pkg.sv
// Shared constants and helpers for the prescaled up/down counter.
package param_counter_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam longint unsigned DEF_MODULUS = 64'd1 << DEF_WIDTH;
  localparam int unsigned DEF_PRESCALE = 50_000_000;

  function automatic int unsigned presc_width(input int unsigned p);
    return (p < 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/param_counter_if.sv
// Control and status bundle between a counter user and param_counter.
interface param_counter_if
  import param_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             enable;
  logic             up;
  logic             saturate;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             step;
  logic             wrap;
  logic             at_max;
  logic             at_min;

  modport master (
    output enable, up, saturate, load, load_value,
    input  count, step, wrap, at_max, at_min
  );

  modport slave (
    input  enable, up, saturate, load, load_value,
    output count, step, wrap, at_max, at_min
  );

endinterface

// File: rtl/param_counter_tick_gen.sv
// Prescaler: one-cycle tick every PRESCALE enabled cycles.
module tick_gen
  import param_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_counter.sv
// Modulo up/down counter stepped by a prescaler, with load, wrap and saturation.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = DEF_WIDTH,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int unsigned     PRESCALE = DEF_PRESCALE
) (
  input logic            CLOCK_50,
  input logic            reset,
  param_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             at_max;
  logic             at_min;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (bus.enable),
    .clear    (bus.load),
    .tick     (tick)
  );

  assign at_max = (count_q == MAXV);
  assign at_min = (count_q == '0);

  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (bus.load) begin
      count_d = (64'(bus.load_value) >= MODULUS) ? MAXV : bus.load_value;
    end else if (tick) begin
      step_d = 1'b1;
      if (bus.up) begin
        if (!at_max) begin
          count_d = count_q + WIDTH'(1);
        end else if (!bus.saturate) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_min) begin
          count_d = count_q - WIDTH'(1);
        end else if (!bus.saturate) begin
          count_d = MAXV;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count_q <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.step   = step_q;
  assign bus.wrap   = wrap_q;
  assign bus.at_max = at_max;
  assign bus.at_min = at_min;

endmodule
